load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the word-addressed data memory port: accepts load and store requests from the core, drives the memory's address, write-enable and write-data lines, and returns sign- or zero-extended load data. The memory only writes whole words, so byte and halfword stores use a read-modify-write sequence. The block sits between the execute stage and the data memory and enforces natural alignment.

## Interface

- No parameters. Data and address widths are fixed at 32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low byte or half is used for B/H.
- `resp_valid`  out  1  one-cycle pulse marking completion.
- `resp_rdata`  out  32  extended load data. It is 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal funct3, qualified by `resp_valid`.
- `mem_a`  out  32  word-aligned address `{addr_q[31:2], 2'b00}`.
- `mem_we`  out  1  memory write enable.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory read data; combinational from `mem_a` in the same cycle.

## Operation

- **States:** IDLE, ACCESS, WRITE, RESP.
- **IDLE:** `req_ready` = 1. When `req_valid` is high at an edge, the block captures `req_we`, `req_funct3`, `req_addr` and `req_wdata`.
- **Error check at capture:**
  - Illegal funct3: 011, 11x, or a store with bit 2 set.
  - H with `addr[0]` = 1.
  - W with `addr[1:0]` ≠ 0.
  - On an error the block goes to RESP with `err_q` = 1 and performs no memory write.
- **Load:** IDLE → ACCESS → RESP.
  - In ACCESS, `mem_a` holds the word address.
  - `mem_rd` is shifted right by `8*addr[1:0]` and masked to the access width.
  - Signed codes (000, 001) sign-extend from bit 7 or bit 15; unsigned codes zero-extend.
  - The result is registered into `resp_rdata`.
- **SW:** IDLE → ACCESS (`mem_we` = 1, `mem_wd` = `wdata_q`) → RESP.
- **SB / SH:** IDLE → ACCESS → WRITE → RESP.
  - In ACCESS, `mem_rd` is merged with `wdata_q[7:0]` or `wdata_q[15:0]` at byte lane `addr[1:0]` (half lane `addr[1]`).
  - The merged word is registered into `merge_q`.
  - In WRITE, `mem_we` = 1 and `mem_wd` = `merge_q`.
- **RESP:** `resp_valid` = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- `mem_we` is 0 in every other state and combination. `mem_a` and `mem_wd` hold their last values when idle.

## Timing

Cycle 0 is the handshake edge.

- Error: `resp_valid` in cycle 1.
- Load or SW: ACCESS in cycle 1; the SW write commits at the end of cycle 1; `resp_valid` in cycle 2.
- SB/SH: read in cycle 1, write in cycle 2, `resp_valid` in cycle 3.
- Back-to-back requests: the next accept is earliest in the cycle after RESP. A request held across a busy period is accepted exactly once.
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `mem_a` 0, `mem_we` 0, `mem_wd` 0, and all capture registers 0.
- Reset asserted mid-operation:
  - `mem_we` drops immediately, asynchronously.
  - No pending write or response is ever issued.
  - A store interrupted before its write edge leaves memory unchanged.
- No combinational path exists from `req_*` to `mem_*`. The only combinational input path is `mem_rd` into the ACCESS-state registers.

## Structure

- **Package `lsu_pkg`:** funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum `lsu_state_t`.
- **Sub-module `lsu_align`:** purely combinational. It provides both the load extract/extend function and the store lane-merge function, from inputs (funct3, `addr[1:0]`, word, wdata). The FSM and registers live in `load_store_unit`.
- Target size is about 200 lines of RTL in total.

## Test plan

All scenarios preload memory word 0x100 = 0xDEADBEEF.

1. LB at 0x103 → `resp_rdata` 0xFFFFFFDE and `resp_err` 0 in cycle 2; `mem_we` never high.
2. LBU at 0x101 → 0x000000BE; LH at 0x100 → 0xFFFFBEEF; LHU at 0x102 → 0x0000DEAD.
3. SB at 0x101 with wdata 0x12345678 → `mem_we` high only in cycle 2 with `mem_wd` 0xDEAD78EF; `resp_valid` in cycle 3; a following LW at 0x100 returns 0xDEAD78EF.
4. SH at 0x101 → `resp_err` 1 and `resp_rdata` 0 in cycle 1; `mem_we` never asserts; memory still 0xDEADBEEF. Funct3 011 produces the same response.
5. SW at 0x100 with 0xCAFEF00D, with `req_valid` held high for 6 cycles → exactly one accept (`req_ready` low in cycles 1–2), then an LW at 0x100 returns 0xCAFEF00D.
6. SB at 0x100, with `rst_n` pulled low during ACCESS → `mem_we` stays 0, no `resp_valid`, memory unchanged; after release, `req_ready` is 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I width codes, FSM states
// and the capture-time legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  // Unsigned width codes are load-only, so a store using them is illegal.
  function automatic logic lsu_req_err(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] off);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B:         err = 1'b0;
      F3_H:         err = off[0];
      F3_W:         err = (off != 2'b00);
      F3_BU, F3_HU: err = we;
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// merges byte/half store data into a word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  always_comb begin
    byte_sh     = {off_i, 3'b000};
    half_sh     = {off_i[1], 4'b0000};
    shifted     = word_i >> byte_sh;
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data_o = {24'b0, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data_o = {16'b0, shifted[15:0]};
      F3_W:    load_data_o = word_i;
      default: load_data_o = '0;
    endcase
  end

  // Only B and H stores reach the merge path; everything else is a half.
  always_comb begin
    if (funct3_i == F3_B) begin
      lane_mask = 32'h0000_00FF << byte_sh;
      lane_data = {24'b0, wdata_i[7:0]} << byte_sh;
    end else begin
      lane_mask = 32'h0000_FFFF << half_sh;
      lane_data = {16'b0, wdata_i[15:0]} << half_sh;
    end
    merge_data_o = (word_i & ~lane_mask) | lane_data;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only data memory: aligned loads with
// extension, whole-word stores, and read-modify-write for byte/half stores.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; resp_valid is a one-cycle pulse with no backpressure.

  lsu_state_t  state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_we_q;
  logic [31:0] mem_wd_q;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_err    = lsu_req_err(req_we, req_funct3, req_addr[1:0]);
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_a      = {addr_q[31:2], 2'b00};
  assign mem_we     = mem_we_q;
  assign mem_wd     = mem_wd_q;

  lsu_align u_align (
    .funct3_i     (funct3_q),
    .off_i        (addr_q[1:0]),
    .word_i       (mem_rd),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            funct3_q     <= req_funct3;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            if (req_err) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= ST_ACCESS;
              // A word store needs no read, so it writes during ACCESS.
              if (req_we && (req_funct3 == F3_W)) begin
                mem_we_q <= 1'b1;
                mem_wd_q <= req_wdata;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            resp_rdata_q <= load_data;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (funct3_q == F3_W) begin
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            // mem_wd_q doubles as the merge register for the write cycle.
            mem_wd_q <= merge_data;
            mem_we_q <= 1'b1;
            state_q  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory and an
// expected-response queue.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word memory: combinational read, write on the rising edge
  logic [31:0] mem [0:1023];
  assign mem_rd = mem[mem_a[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[11:2]] <= mem_wd;

  int checks;
  int failures;
  logic [32:0] exp_q[$];
  logic [32:0] sb_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard: each response pops {err, rdata}
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_resp_err", {31'b0, resp_err}, {31'b0, sb_e[32]});
        check("sb_resp_rdata", resp_rdata, sb_e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic preload();
    @(negedge clk);
    mem[64]  <= 32'hDEAD_BEEF;
    mem[128] <= 32'h0000_0000;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // issue one request and track cycle-level timing for 4 cycles after the handshake
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int resp_cyc, input logic err, input logic [31:0] rdata,
                         input int we_cyc, input logic [31:0] wd);
    int got_resp_cyc;
    int got_we_cyc;
    int we_cnt;
    got_resp_cyc = 0;
    got_we_cyc   = 0;
    we_cnt       = 0;
    exp_q.push_back({err, rdata});
    issue(we, f3, addr, wdata);
    for (int c = 1; c <= 4; c++) begin
      if (c == 1 && !err) check({tag, "_mem_a"}, mem_a, {addr[31:2], 2'b00});
      if (resp_valid && got_resp_cyc == 0) got_resp_cyc = c;
      if (mem_we) begin
        we_cnt++;
        got_we_cyc = c;
        check({tag, "_mem_wd"}, mem_wd, wd);
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_resp_cyc"}, got_resp_cyc, resp_cyc);
    check({tag, "_we_cnt"}, we_cnt, (we_cyc != 0) ? 32'd1 : 32'd0);
    check({tag, "_we_cyc"}, got_we_cyc, we_cyc);
  endtask

  logic rdy_hist [1:6];
  int   accepts;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1-2: loads with extension
    preload();
    run_req("lb103",  1'b0, F3_B,  32'h103, 32'h0, 2, 1'b0, 32'hFFFF_FFDE, 0, 32'h0);
    run_req("lbu101", 1'b0, F3_BU, 32'h101, 32'h0, 2, 1'b0, 32'h0000_00BE, 0, 32'h0);
    run_req("lh100",  1'b0, F3_H,  32'h100, 32'h0, 2, 1'b0, 32'hFFFF_BEEF, 0, 32'h0);
    run_req("lhu102", 1'b0, F3_HU, 32'h102, 32'h0, 2, 1'b0, 32'h0000_DEAD, 0, 32'h0);
    run_req("lw100",  1'b0, F3_W,  32'h100, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 0, 32'h0);

    // 3: byte store read-modify-write, then read back
    run_req("sb101", 1'b1, F3_B, 32'h101, 32'h1234_5678, 3, 1'b0, 32'h0, 2, 32'hDEAD_78EF);
    run_req("lw_after_sb", 1'b0, F3_W, 32'h100, 32'h0, 2, 1'b0, 32'hDEAD_78EF, 0, 32'h0);
    run_req("sh102", 1'b1, F3_H, 32'h102, 32'h0000_A55A, 3, 1'b0, 32'h0, 2, 32'hA55A_78EF);

    // 4: errors
    preload();
    run_req("sh_mis", 1'b1, F3_H, 32'h101, 32'h1234_5678, 1, 1'b1, 32'h0, 0, 32'h0);
    check("mem_after_err", mem[64], 32'hDEAD_BEEF);
    run_req("f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 1, 1'b1, 32'h0, 0, 32'h0);
    run_req("lw_mis", 1'b0, F3_W, 32'h102, 32'h0, 1, 1'b1, 32'h0, 0, 32'h0);
    run_req("sbu_ill", 1'b1, F3_BU, 32'h100, 32'hFF, 1, 1'b1, 32'h0, 0, 32'h0);
    check("mem_after_errs", mem[64], 32'hDEAD_BEEF);

    // 5: SW held high across a busy SB, accepted exactly once
    preload();
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, F3_B, 32'h200, 32'h0000_0055);
    exp_q.push_back({1'b0, 32'h0});
    accepts = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h100;
    req_wdata  = 32'hCAFE_F00D;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      rdy_hist[k] = req_ready;
      if (req_ready) accepts++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("t5_accepts", accepts, 32'd1);
    check("t5_ready_c4", {31'b0, rdy_hist[4]}, 32'd1);
    check("t5_ready_c5", {31'b0, rdy_hist[5]}, 32'd0);
    check("t5_ready_c6", {31'b0, rdy_hist[6]}, 32'd0);
    check("t5_sb_mem", mem[128], 32'h0000_0055);
    run_req("lw_after_sw", 1'b0, F3_W, 32'h100, 32'h0, 2, 1'b0, 32'hCAFE_F00D, 0, 32'h0);

    // 6: reset during ACCESS of a byte store
    preload();
    issue(1'b1, F3_B, 32'h100, 32'h1234_5678);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_we_in_rst", {31'b0, mem_we}, 32'd0);
    check("t6_ready_in_rst", {31'b0, req_ready}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("t6_we_hold", {31'b0, mem_we}, 32'd0);
      check("t6_valid_hold", {31'b0, resp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t6_we_after", {31'b0, mem_we}, 32'd0);
      check("t6_valid_after", {31'b0, resp_valid}, 32'd0);
    end
    check("t6_ready_after", {31'b0, req_ready}, 32'd1);
    check("t6_mem_a_after", mem_a, 32'd0);
    check("t6_mem_unchanged", mem[64], 32'hDEAD_BEEF);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
